// File: rtl/load_store_unit.sv
// Load/store unit: turns an ALU effective address into a word-organised data memory
// req/ack transaction and returns an aligned, extended load value or an error response.
module load_store_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  access_err,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [3:0]            dmem_be,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_ack,
   input  logic [DATA_WIDTH-1:0] dmem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, next_state;

   logic [ADDR_WIDTH+1:0] addr_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  write_q;
   logic                  err_q;
   logic [31:0]           count_q;

   logic accept;
   logic funct3_ok;
   logic illegal;
   logic misaligned;
   logic req_err;
   logic timeout_hit;
   logic unused_addr_bits;

   logic [7:0]            byte_lane;
   logic [15:0]           half_lane;
   logic [DATA_WIDTH-1:0] ext_data;
   logic [3:0]            store_be;
   logic [DATA_WIDTH-1:0] store_wdata;

   assign unused_addr_bits = ^alu_result[DATA_WIDTH-1:ADDR_WIDTH+2];

   // Unsigned load widths have no store counterpart.
   always_comb begin
      funct3_ok = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
         3'b100, 3'b101:         funct3_ok = ~mem_write;
         default:                funct3_ok = 1'b0;
      endcase
   end

   assign accept      = (state == IDLE) && req_valid && (mem_read || mem_write);
   assign illegal     = (mem_read && mem_write) || !funct3_ok;
   assign misaligned  = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                        ((funct3 == 3'b010) && (alu_result[1:0] != 2'b00));
   assign req_err     = illegal || misaligned;
   assign timeout_hit = (ACK_TIMEOUT != 0) && (count_q == 32'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = req_err ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            if (dmem_ack || timeout_hit) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request context is frozen at accept so the memory side stays stable during ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         funct3_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
      end else if (accept) begin
         addr_q   <= alu_result[ADDR_WIDTH+1:0];
         funct3_q <= funct3;
         wdata_q  <= store_data;
         rdata_q  <= '0;
         write_q  <= mem_write;
         err_q    <= req_err;
         count_q  <= '0;
      end else if (state == ACCESS) begin
         if (dmem_ack) begin
            rdata_q <= dmem_rdata;
         end else begin
            count_q <= count_q + 32'd1;
            if (timeout_hit) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   byte_lane = rdata_q[7:0];
         2'b01:   byte_lane = rdata_q[15:8];
         2'b10:   byte_lane = rdata_q[23:16];
         default: byte_lane = rdata_q[31:24];
      endcase
      half_lane = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

      case (funct3_q)
         3'b000:  ext_data = {{24{byte_lane[7]}}, byte_lane};
         3'b100:  ext_data = {24'd0, byte_lane};
         3'b001:  ext_data = {{16{half_lane[15]}}, half_lane};
         3'b101:  ext_data = {16'd0, half_lane};
         default: ext_data = rdata_q;
      endcase

      case (funct3_q[1:0])
         2'b00: begin
            store_be    = 4'b0001 << addr_q[1:0];
            store_wdata = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            store_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{wdata_q[15:0]}};
         end
         default: begin
            store_be    = 4'b1111;
            store_wdata = wdata_q;
         end
      endcase
   end

   // Memory-side outputs are only non-zero during ACCESS; response outputs only in DONE.
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = 1'b0;
      load_data  = '0;
      access_err = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_be    = 4'b0000;
      dmem_addr  = '0;
      dmem_wdata = '0;
      if (state == ACCESS) begin
         dmem_req   = 1'b1;
         dmem_we    = write_q;
         dmem_be    = write_q ? store_be : 4'b1111;
         dmem_addr  = addr_q[ADDR_WIDTH+1:2];
         dmem_wdata = write_q ? store_wdata : '0;
      end
      if (state == DONE) begin
         resp_valid = 1'b1;
         access_err = err_q;
         load_data  = (err_q || write_q) ? '0 : ext_data;
      end
   end

endmodule
